fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// FIFO pointer/occupancy controller; almost flags compiled in by FIFO_CTRL_ALMOST_FLAGS_EN.
// Latency: write/read strobes are combinational; count, flags and pointers update on the next edge.
// Backpressure: pushes are rejected when FULL unless a pop is accepted in the same cycle; pops are rejected when EMPTY.
module fifo_ctrl #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    input  logic [PTR_W-1:0] af_thresh,
    input  logic [PTR_W-1:0] ae_thresh,
`endif
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic             write,
    output logic             read,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    output logic             almost_full,
    output logic             almost_empty
`endif
);

    localparam logic [PTR_W:0]   DEPTH   = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_FULL} state_t;

    state_t         state;
    logic           push_ok;
    logic           pop_ok;
    logic           ovf_evt;
    logic           unf_evt;
    logic [PTR_W:0] count_nxt;

    assign empty = (state == S_EMPTY);
    assign full  = (state == S_FULL);

    // A push into FULL is only legal when a pop frees the slot in the same cycle.
    assign push_ok = !reset && push && ((state != S_FULL) || pop);
    assign pop_ok  = !reset && pop && (state != S_EMPTY);
    assign write   = push_ok;
    assign read    = pop_ok;

    assign ovf_evt = push && !pop && (state == S_FULL);
    assign unf_evt = pop && (state == S_EMPTY);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + CNT_ONE;
        else if (pop_ok && !push_ok)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            count     <= count_nxt;
            // Set wins over clear so an error coincident with err_clr is not lost.
            overflow  <= ovf_evt || (overflow && !err_clr);
            underflow <= unf_evt || (underflow && !err_clr);
            case (state)
                S_EMPTY:
                    if (push_ok && !pop_ok)
                        state <= S_ACTIVE;
                S_ACTIVE:
                    if (push_ok && !pop_ok && (count_nxt == DEPTH))
                        state <= S_FULL;
                    else if (pop_ok && !push_ok && (count_nxt == '0))
                        state <= S_EMPTY;
                S_FULL:
                    if (pop_ok && !push_ok)
                        state <= S_ACTIVE;
                default:
                    state <= S_EMPTY;
            endcase
        end
    end

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= {1'b0, af_thresh});
            almost_empty <= (count_nxt <= {1'b0, ae_thresh});
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: storage array driven by the controller strobes, data scoreboard plus occupancy model.
// Inputs change on the falling edge; outputs are sampled mid-cycle and 1 ns after the rising edge.
module tb_fifo_ctrl;

    localparam int PTR_W = 3;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             err_clr = 1'b0;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             write;
    logic             read;
    logic             full;
    logic             empty;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic             underflow;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    logic [PTR_W-1:0] af_thresh = 3'd6;
    logic [PTR_W-1:0] ae_thresh = 3'd1;
    logic             almost_full;
    logic             almost_empty;
`endif

    fifo_ctrl #(.PTR_W(PTR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .err_clr      (err_clr),
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
`endif
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .write        (write),
        .read         (read),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    logic [11:0] mem [0:DEPTH-1];
    logic [11:0] wdata = '0;

    always @(posedge clk)
        if (write)
            mem[wr_ptr] <= wdata;

    int          n_chk = 0;
    int          n_bad = 0;
    int          m_cnt;
    logic [2:0]  m_wp;
    logic [2:0]  m_rp;
    bit          m_ovf;
    bit          m_unf;
    logic [11:0] sb [$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0;
        m_wp  = '0;
        m_rp  = '0;
        m_ovf = 0;
        m_unf = 0;
        sb.delete();
    endtask

    task automatic check_regs();
        chk("count", int'(count), m_cnt);
        chk("wr_ptr", int'(wr_ptr), int'(m_wp));
        chk("rd_ptr", int'(rd_ptr), int'(m_rp));
        chk("full", int'(full), int'(m_cnt == DEPTH));
        chk("empty", int'(empty), int'(m_cnt == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("underflow", int'(underflow), int'(m_unf));
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        chk("almost_full", int'(almost_full), int'(m_cnt >= 6));
        chk("almost_empty", int'(almost_empty), int'(m_cnt <= 1));
`endif
    endtask

    task automatic step(input bit p, input bit q, input bit ec);
        bit          acc_push;
        bit          acc_pop;
        bit          full_m;
        bit          empty_m;
        logic [11:0] exp_dat;
        @(negedge clk);
        push    = p;
        pop     = q;
        err_clr = ec;
        wdata   = 12'($urandom_range(0, 4095));
        full_m   = (m_cnt == DEPTH);
        empty_m  = (m_cnt == 0);
        acc_push = p && (!full_m || q);
        acc_pop  = q && !empty_m;
        if (acc_push)
            sb.push_back(wdata);
        #1;
        chk("write", int'(write), int'(acc_push));
        chk("read", int'(read), int'(acc_pop));
        if (acc_pop) begin
            exp_dat = sb.pop_front();
            chk("rdata", int'(mem[rd_ptr]), int'(exp_dat));
        end
        m_ovf = (p && !q && full_m) || (m_ovf && !ec);
        m_unf = (q && empty_m) || (m_unf && !ec);
        m_cnt = m_cnt + int'(acc_push) - int'(acc_pop);
        if (acc_push) m_wp = m_wp + 3'd1;
        if (acc_pop)  m_rp = m_rp + 3'd1;
        @(posedge clk);
        #1;
        check_regs();
    endtask

    initial begin
        m_reset();
        // Requests held high while in reset must be ignored.
        push = 1'b1;
        pop  = 1'b1;
        #2;
        check_regs();
        chk("rst_write", int'(write), 0);
        chk("rst_read", int'(read), 0);
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        chk("rst_write_edge", int'(write), 0);
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            step(1, 0, 0);
            chk("fill_count", int'(count), i + 1);
        end
        chk("full8", int'(full), 1);
        chk("wp_wrap", int'(wr_ptr), 0);

        step(1, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 8);
        chk("ovf_wp", int'(wr_ptr), 0);
        chk("ovf_rp", int'(rd_ptr), 0);
        step(0, 0, 1);
        chk("ovf_clr", int'(overflow), 0);

        repeat (3) step(1, 1, 0);
        chk("ff_count", int'(count), 8);
        chk("ff_full", int'(full), 1);
        chk("ff_wp", int'(wr_ptr), 3);
        chk("ff_rp", int'(rd_ptr), 3);

        repeat (DEPTH) step(0, 1, 0);
        chk("drained", int'(empty), 1);

        step(1, 1, 0);
        chk("pp_empty_count", int'(count), 1);
        chk("pp_empty_unf", int'(underflow), 1);
        step(0, 0, 1);
        step(0, 1, 0);

        // Error set coincident with clear must win.
        step(0, 1, 1);
        chk("unf_set_wins", int'(underflow), 1);
        step(0, 0, 1);

        repeat (400)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));

        for (int i = 0; i < 20 && m_cnt != 5; i++)
            step(m_cnt < 5, m_cnt > 5, 1'b0);
        chk("pre_rst_count", int'(count), 5);

        @(negedge clk);
        push = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_wp", int'(wr_ptr), 0);
        chk("mid_rst_rp", int'(rd_ptr), 0);
        chk("mid_rst_write", int'(write), 0);
        check_regs();
        @(negedge clk);
        reset = 1'b0;
        push  = 1'b0;
        step(1, 0, 0);
        chk("post_rst_wp", int'(wr_ptr), 1);
        step(0, 1, 0);
        chk("post_rst_rp", int'(rd_ptr), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
